// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: upstream decoded instruction, forwarding taps and execute-side operands.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// master: drives instructions and consumes operands (decode + execute side).
// slave : the id_ex_stage itself.
interface id_ex_stage_if #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 16
);
   // upstream instruction
   logic             in_valid;
   logic             in_ready;
   logic [AW-1:0]    rs;
   logic [AW-1:0]    rt;
   logic [AW-1:0]    rd;
   logic [DW-1:0]    read_data1;
   logic [DW-1:0]    read_data2;
   logic [DW-1:0]    imm;
   logic             reg_write;
   logic             mem_to_reg;
   logic             mem_read;
   logic             mem_write;
   logic             alu_src;
   logic [3:0]       alu_op;
   logic             flush;
   // forwarding taps
   logic             exmem_reg_write;
   logic [AW-1:0]    exmem_rd;
   logic [DW-1:0]    exmem_result;
   logic             memwb_reg_write;
   logic [AW-1:0]    memwb_rd;
   logic [DW-1:0]    memwb_data;
   // execute side
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    operand_a;
   logic [DW-1:0]    operand_b;
   logic [DW-1:0]    store_data;
   logic [AW-1:0]    rd_out;
   logic [3:0]       alu_op_out;
   logic             reg_write_out;
   logic             mem_to_reg_out;
   logic             mem_read_out;
   logic             mem_write_out;
   logic             alu_src_out;
   // status
   logic             load_use_stall;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output in_valid, rs, rt, rd, read_data1, read_data2, imm,
             reg_write, mem_to_reg, mem_read, mem_write, alu_src, alu_op, flush,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_data, out_ready,
      input  in_ready, out_valid, operand_a, operand_b, store_data, rd_out, alu_op_out,
             reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out, alu_src_out,
             load_use_stall, stall_cycles
   );

   modport slave (
      input  in_valid, rs, rt, rd, read_data1, read_data2, imm,
             reg_write, mem_to_reg, mem_read, mem_write, alu_src, alu_op, flush,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_data, out_ready,
      output in_ready, out_valid, operand_a, operand_b, store_data, rd_out, alu_op_out,
             reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out, alu_src_out,
             load_use_stall, stall_cycles
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX stage: captures operands with EX/MEM > MEM/WB forwarding, stalls on load-use.
// Latency: 1 cycle from accepted input to out_valid; single-entry buffer.
// Backpressure: in_ready low while the entry is held (out_ready=0), on load-use hazard or flush.
// Ports: clk, rst_n (synchronous, active low); bus (slave) carries the upstream instruction
// (in_valid/in_ready, rs/rt/rd, read_data1/2, imm, control, alu_op, flush), the EX/MEM and
// MEM/WB forwarding taps, the execute-side operands (out_valid/out_ready, operand_a/b,
// store_data, rd_out, *_out control) and the load_use_stall / stall_cycles status.
module id_ex_stage #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   id_ex_stage_if.slave  bus
);

   logic [DW-1:0]    fwd_rs;
   logic [DW-1:0]    fwd_rt;
   logic             uses_rt;
   logic             stall;
   logic             ready;

   logic             out_valid_q;
   logic [DW-1:0]    operand_a_q;
   logic [DW-1:0]    operand_b_q;
   logic [DW-1:0]    store_data_q;
   logic [AW-1:0]    rd_q;
   logic [3:0]       alu_op_q;
   logic             reg_write_q;
   logic             mem_to_reg_q;
   logic             mem_read_q;
   logic             mem_write_q;
   logic             alu_src_q;
   logic [CNT_W-1:0] stall_cnt_q;

   // Forwarding muxes: the younger EX/MEM result wins over MEM/WB. The rd!=0 term keeps
   // r0 from ever being forwarded, since rd==rs then implies rs!=0.
   always_comb begin
      fwd_rs = bus.read_data1;
      if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.rs))
         fwd_rs = bus.exmem_result;
      else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.rs))
         fwd_rs = bus.memwb_data;
   end

   always_comb begin
      fwd_rt = bus.read_data2;
      if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.rt))
         fwd_rt = bus.exmem_result;
      else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.rt))
         fwd_rt = bus.memwb_data;
   end

   // rt only matters when it feeds the ALU or supplies store data.
   assign uses_rt = !bus.alu_src || bus.mem_write;

   // A held load whose destination the incoming instruction reads: its data does not
   // exist yet, so the consumer must wait until the load has moved on.
   assign stall = bus.in_valid && out_valid_q && mem_read_q && (rd_q != '0) &&
                  ((rd_q == bus.rs) || (uses_rt && (rd_q == bus.rt)));

   assign ready = (!out_valid_q || bus.out_ready) && !stall && !bus.flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         operand_a_q  <= '0;
         operand_b_q  <= '0;
         store_data_q <= '0;
         rd_q         <= '0;
         alu_op_q     <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         alu_src_q    <= 1'b0;
      end else if (bus.flush) begin
         // payload is left as-is; only the valid bit is killed
         out_valid_q <= 1'b0;
      end else if (bus.in_valid && ready) begin
         out_valid_q  <= 1'b1;
         operand_a_q  <= fwd_rs;
         operand_b_q  <= bus.alu_src ? bus.imm : fwd_rt;
         store_data_q <= fwd_rt;
         rd_q         <= bus.rd;
         alu_op_q     <= bus.alu_op;
         reg_write_q  <= bus.reg_write;
         mem_to_reg_q <= bus.mem_to_reg;
         mem_read_q   <= bus.mem_read;
         mem_write_q  <= bus.mem_write;
         alu_src_q    <= bus.alu_src;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Saturating hazard counter; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_q <= stall_cnt_q + 1'b1;
   end

   assign bus.in_ready       = ready;
   assign bus.load_use_stall = stall;
   assign bus.stall_cycles   = stall_cnt_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.operand_a      = operand_a_q;
   assign bus.operand_b      = operand_b_q;
   assign bus.store_data     = store_data_q;
   assign bus.rd_out         = rd_q;
   assign bus.alu_op_out     = alu_op_q;
   assign bus.reg_write_out  = reg_write_q;
   assign bus.mem_to_reg_out = mem_to_reg_q;
   assign bus.mem_read_out   = mem_read_q;
   assign bus.mem_write_out  = mem_write_q;
   assign bus.alu_src_out    = alu_src_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic [3:0]  op;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   exp_t sbq[$];
   exp_t e;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk_exp(input logic [31:0] a, b, sd, input logic [4:0] rd,
                                   input logic [3:0] op);
      exp_t x;
      x.a = a; x.b = b; x.sd = sd; x.rd = rd; x.op = op;
      return x;
   endfunction

   function automatic exp_t out_vec();
      return {bus.operand_a, bus.operand_b, bus.store_data, bus.rd_out, bus.alu_op_out};
   endfunction

   task automatic drive_instr(input logic [4:0] rs, rt, rd, input logic [31:0] d1, d2, imm,
                              input logic src, mrd, mwr, input logic [3:0] op);
      bus.in_valid   = 1'b1;
      bus.rs         = rs;
      bus.rt         = rt;
      bus.rd         = rd;
      bus.read_data1 = d1;
      bus.read_data2 = d2;
      bus.imm        = imm;
      bus.alu_src    = src;
      bus.mem_read   = mrd;
      bus.mem_to_reg = mrd;
      bus.mem_write  = mwr;
      bus.reg_write  = !mwr;
      bus.alu_op     = op;
   endtask

   task automatic clear_fwd();
      bus.exmem_reg_write = 1'b0;
      bus.exmem_rd        = '0;
      bus.exmem_result    = '0;
      bus.memwb_reg_write = 1'b0;
      bus.memwb_rd        = '0;
      bus.memwb_data      = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      clear_fwd();
      drive_instr(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0, 1'b0, 4'h1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.operand_a !== 32'h0) $display("FAIL reset_operand_a: got %h want 0", bus.operand_a);
      else n_pass++;
      n_checks++;
      if (bus.stall_cycles !== 16'h0) $display("FAIL reset_stall_cycles: got %0d want 0", bus.stall_cycles);
      else n_pass++;
      n_checks++;
      if (bus.rd_out !== 5'h0) $display("FAIL reset_rd_out: got %0d want 0", bus.rd_out);
      else n_pass++;
      step();
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_no_hazard();
      drive_instr(5'd1, 5'd3, 5'd4, 32'd6, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 4'h2);
      bus.out_ready = 1'b1;
      sbq.push_back(mk_exp(32'd6, 32'd3, 32'd3, 5'd4, 4'h2));
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL nohaz_in_ready: got %b want 1", bus.in_ready);
      else n_pass++;
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL nohaz_out_valid: got %b want 1", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (sbq.size() == 0) $display("FAIL nohaz_data: scoreboard empty");
      else begin
         e = sbq.pop_front();
         if (out_vec() !== e) $display("FAIL nohaz_data: got %h want %h", out_vec(), e);
         else n_pass++;
      end
      n_checks++;
      if (bus.reg_write_out !== 1'b1) $display("FAIL nohaz_reg_write_out: got %b want 1", bus.reg_write_out);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL nohaz_drain: got %b want 0", bus.out_valid);
      else n_pass++;
      step();
   endtask

   // Three instructions on consecutive edges, each exercising a different forwarding source.
   task automatic test_forward_back_to_back();
      bus.out_ready = 1'b1;
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd20; bus.exmem_result = 32'h55;
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd20; bus.memwb_data = 32'h99;
      drive_instr(5'd20, 5'd0, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0, 1'b0, 4'h3);
      sbq.push_back(mk_exp(32'h55, 32'h22, 32'h22, 5'd7, 4'h3));
      step();
      bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0;
      drive_instr(5'd0, 5'd0, 5'd8, 32'h33, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 4'h4);
      sbq.push_back(mk_exp(32'h33, 32'h44, 32'h44, 5'd8, 4'h4));
      @(negedge clk);
      n_checks++;
      if (sbq.size() == 0) $display("FAIL fwd_exmem_prio: scoreboard empty");
      else begin
         e = sbq.pop_front();
         if (out_vec() !== e) $display("FAIL fwd_exmem_prio: got %h want %h", out_vec(), e);
         else n_pass++;
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready);
      else n_pass++;
      step();
      bus.exmem_rd = 5'd20; bus.memwb_rd = 5'd9;
      drive_instr(5'd9, 5'd9, 5'd10, 32'h1, 32'h2, 32'd5, 1'b1, 1'b0, 1'b0, 4'h5);
      sbq.push_back(mk_exp(32'h99, 32'd5, 32'h99, 5'd10, 4'h5));
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL b2b_out_valid: got %b want 1", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (sbq.size() == 0) $display("FAIL fwd_r0: scoreboard empty");
      else begin
         e = sbq.pop_front();
         if (out_vec() !== e) $display("FAIL fwd_r0: got %h want %h", out_vec(), e);
         else n_pass++;
      end
      step();
      bus.in_valid = 1'b0;
      clear_fwd();
      @(negedge clk);
      n_checks++;
      if (sbq.size() == 0) $display("FAIL fwd_memwb_imm: scoreboard empty");
      else begin
         e = sbq.pop_front();
         if (out_vec() !== e) $display("FAIL fwd_memwb_imm: got %h want %h", out_vec(), e);
         else n_pass++;
      end
      step();
   endtask

   task automatic test_load_use();
      bus.out_ready = 1'b0;
      drive_instr(5'd1, 5'd0, 5'd25, 32'h100, 32'h0, 32'd8, 1'b1, 1'b1, 1'b0, 4'h0);
      sbq.push_back(mk_exp(32'h100, 32'd8, 32'h0, 5'd25, 4'h0));
      step();
      // rt matches the load but an immediate-form non-store never reads rt
      drive_instr(5'd3, 5'd25, 5'd26, 32'h5, 32'h6, 32'h10, 1'b1, 1'b0, 1'b0, 4'h1);
      @(negedge clk);
      n_checks++;
      if (bus.load_use_stall !== 1'b0) $display("FAIL lu_rt_unused: got %b want 0", bus.load_use_stall);
      else n_pass++;
      n_checks++;
      if (bus.mem_read_out !== 1'b1) $display("FAIL lu_mem_read_out: got %b want 1", bus.mem_read_out);
      else n_pass++;
      step();
      drive_instr(5'd25, 5'd2, 5'd26, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0, 1'b0, 4'h1);
      bus.out_ready = 1'b1;
      sbq.push_back(mk_exp(32'hABC, 32'h7, 32'h7, 5'd26, 4'h1));
      @(negedge clk);
      n_checks++;
      if (bus.load_use_stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", bus.load_use_stall);
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL lu_in_ready: got %b want 0", bus.in_ready);
      else n_pass++;
      n_checks++;
      if (sbq.size() == 0) $display("FAIL lu_load_data: scoreboard empty");
      else begin
         e = sbq.pop_front();
         if (out_vec() !== e) $display("FAIL lu_load_data: got %h want %h", out_vec(), e);
         else n_pass++;
      end
      step();
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd25; bus.memwb_data = 32'hABC;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL lu_drained: got %b want 0", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL lu_release: got %b want 1", bus.in_ready);
      else n_pass++;
      n_checks++;
      if (bus.stall_cycles !== 16'd1) $display("FAIL lu_stall_cycles: got %0d want 1", bus.stall_cycles);
      else n_pass++;
      step();
      bus.in_valid = 1'b0;
      clear_fwd();
      @(negedge clk);
      n_checks++;
      if (sbq.size() == 0) $display("FAIL lu_consumer: scoreboard empty");
      else begin
         e = sbq.pop_front();
         if (out_vec() !== e) $display("FAIL lu_consumer: got %h want %h", out_vec(), e);
         else n_pass++;
      end
      step();
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      drive_instr(5'd4, 5'd5, 5'd11, 32'h40, 32'h50, 32'h0, 1'b0, 1'b0, 1'b0, 4'h6);
      sbq.push_back(mk_exp(32'h40, 32'h50, 32'h50, 5'd11, 4'h6));
      step();
      drive_instr(5'd6, 5'd7, 5'd12, 32'h60, 32'h70, 32'h0, 1'b0, 1'b0, 1'b0, 4'h7);
      sbq.push_back(mk_exp(32'h60, 32'h70, 32'h70, 5'd12, 4'h7));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b1 || out_vec() !== sbq[0])
            $display("FAIL bp_hold_%0d: got v=%b %h want v=1 %h", i, bus.out_valid, out_vec(), sbq[0]);
         else n_pass++;
         n_checks++;
         if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b want 0", i, bus.in_ready);
         else n_pass++;
         step();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", bus.in_ready);
      else n_pass++;
      n_checks++;
      if (sbq.size() == 0) $display("FAIL bp_first: scoreboard empty");
      else begin
         e = sbq.pop_front();
         if (out_vec() !== e) $display("FAIL bp_first: got %h want %h", out_vec(), e);
         else n_pass++;
      end
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sbq.size() == 0) $display("FAIL bp_second: scoreboard empty");
      else begin
         e = sbq.pop_front();
         if (bus.out_valid !== 1'b1 || out_vec() !== e)
            $display("FAIL bp_second: got v=%b %h want v=1 %h", bus.out_valid, out_vec(), e);
         else n_pass++;
      end
      step();
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      drive_instr(5'd8, 5'd9, 5'd13, 32'h80, 32'h90, 32'h0, 1'b0, 1'b0, 1'b0, 4'h8);
      step();
      drive_instr(5'd5, 5'd0, 5'd14, 32'h1, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 4'h9);
      bus.flush = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", bus.in_ready);
      else n_pass++;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.operand_a !== 32'h80)
         $display("FAIL flush_held: got v=%b a=%h want v=1 a=80", bus.out_valid, bus.operand_a);
      else n_pass++;
      step();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL flush_kill: got %b want 0", bus.out_valid);
      else n_pass++;
      step();
      drive_instr(5'd5, 5'd0, 5'd14, 32'h1, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 4'h9);
      bus.out_ready = 1'b1;
      sbq.push_back(mk_exp(32'h1, 32'hFFFF_FFFC, 32'h0, 5'd14, 4'h9));
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sbq.size() == 0) $display("FAIL flush_neg_imm: scoreboard empty");
      else begin
         e = sbq.pop_front();
         if (out_vec() !== e) $display("FAIL flush_neg_imm: got %h want %h", out_vec(), e);
         else n_pass++;
      end
      n_checks++;
      if (bus.alu_src_out !== 1'b1) $display("FAIL flush_alu_src_out: got %b want 1", bus.alu_src_out);
      else n_pass++;
      step();
   endtask

   task automatic test_mid_reset();
      bus.out_ready = 1'b0;
      drive_instr(5'd2, 5'd3, 5'd15, 32'h20, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0, 4'h1);
      step();
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.stall_cycles !== 16'd1)
         $display("FAIL mrst_pre: got v=%b cnt=%0d want v=1 cnt=1", bus.out_valid, bus.stall_cycles);
      else n_pass++;
      step();
      rst_n = 1'b0;
      bus.flush = 1'b1;
      step();
      rst_n = 1'b1;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.operand_a !== 32'h0 || bus.stall_cycles !== 16'd0)
         $display("FAIL mrst_post: got v=%b a=%h cnt=%0d want v=0 a=0 cnt=0",
                  bus.out_valid, bus.operand_a, bus.stall_cycles);
      else n_pass++;
      step();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_no_hazard();
      test_forward_back_to_back();
      test_load_use();
      test_backpressure();
      test_flush();
      test_mid_reset();
      n_checks++;
      if (sbq.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
